// File: rtl/dmem_arb_pkg.sv
// Shared types and default parameters for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {OWN_CPU = 1'b0, OWN_LD = 1'b1} owner_e;
  typedef enum logic {ARB = 1'b0, BURST = 1'b1} arb_state_e;

  localparam int AW_DEF        = 32;
  localparam int DW_DEF        = 32;
  localparam int RD_LAT_DEF    = 1;
  localparam int BURST_MAX_DEF = 8;
  localparam int MAX_WAIT_DEF  = 4;

endpackage

// File: rtl/rd_tag_pipe.sv
// Tracks issued reads (valid + owner) across the memory read latency so that
// returning data can be steered back to whoever asked for it.
module rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int LAT = RD_LAT_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   vld_i,
  input  owner_e own_i,
  output logic   vld_o,
  output owner_e own_o
);

  generate
    if (LAT == 0) begin : g_comb
      assign vld_o = vld_i;
      assign own_o = own_i;
    end else begin : g_pipe
      logic [LAT-1:0] vld_q;
      owner_e         own_q [LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          for (int i = 0; i < LAT; i++) own_q[i] <= OWN_CPU;
        end else begin
          vld_q[0] <= vld_i;
          own_q[0] <= own_i;
          for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            own_q[i] <= own_q[i-1];
          end
        end
      end

      assign vld_o = vld_q[LAT-1];
      assign own_o = own_q[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU memory stage and the loader,
// with lockable loader bursts, anti-starvation and read-data return routing.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int RD_LAT    = RD_LAT_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int MAX_WAIT  = MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic          ld_lock,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX + 1) : 1;

  arb_state_e    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [BW-1:0] beat_q, beat_d;

  logic   cpu_win, ld_win, burst_hit;
  logic   rd_vld, ret_vld;
  owner_e rd_own, ret_own;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      wait_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
    end
  end

  // An unlocked loader request during a burst is arbitrated like in ARB.
  always_comb begin
    cpu_win   = 1'b0;
    ld_win    = 1'b0;
    burst_hit = 1'b0;
    if (state_q == BURST && ld_req && ld_lock) begin
      ld_win    = 1'b1;
      burst_hit = 1'b1;
    end else if (ld_req && (!cpu_req || wait_q == WW'(MAX_WAIT))) begin
      ld_win = 1'b1;
    end else if (cpu_req) begin
      cpu_win = 1'b1;
    end
  end

  always_comb begin
    state_d = ARB;
    beat_d  = '0;
    wait_d  = wait_q;
    if (!ld_req || ld_win) begin
      wait_d = '0;
    end else if (wait_q != WW'(MAX_WAIT)) begin
      wait_d = wait_q + WW'(1);
    end
    // Hitting BURST_MAX drops to ARB with wait_cnt already cleared by the grant.
    if (burst_hit) begin
      if (beat_q < BW'(BURST_MAX - 1)) begin
        state_d = BURST;
        beat_d  = beat_q + BW'(1);
      end
    end else if (ld_win && ld_lock && BURST_MAX > 1) begin
      state_d = BURST;
      beat_d  = BW'(1);
    end
  end

  assign cpu_gnt   = cpu_win & ~rst;
  assign ld_gnt    = ld_win & ~rst;
  assign cpu_stall = cpu_req & ~cpu_win & ~rst;

  always_comb begin
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 1'b0;
    if (ld_gnt) begin
      mem_a  = ld_addr;
      mem_wd = ld_wdata;
      mem_we = ld_we;
    end else if (cpu_gnt) begin
      mem_a  = cpu_addr;
      mem_wd = cpu_wdata;
      mem_we = cpu_we;
    end
  end

  assign rd_vld = (cpu_gnt & ~cpu_we) | (ld_gnt & ~ld_we);
  assign rd_own = ld_gnt ? OWN_LD : OWN_CPU;

  rd_tag_pipe #(
    .LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .vld_i (rd_vld),
    .own_i (rd_own),
    .vld_o (ret_vld),
    .own_o (ret_own)
  );

  assign cpu_rvalid = ret_vld & (ret_own == OWN_CPU) & ~rst;
  assign ld_rvalid  = ret_vld & (ret_own == OWN_LD) & ~rst;
  assign cpu_rdata  = cpu_rvalid ? mem_rd : '0;
  assign ld_rdata   = ld_rvalid ? mem_rd : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed grant/burst/reset checks plus
// a read-return scoreboard fed from the requesters' own addresses.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, ld_req, ld_we, ld_lock;
  logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, ld_gnt, ld_rvalid, mem_we;
  logic [31:0] cpu_rdata, ld_rdata, mem_a, mem_wd, mem_rd;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ld_req     (ld_req),
    .ld_we      (ld_we),
    .ld_lock    (ld_lock),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_gnt     (ld_gnt),
    .ld_rvalid  (ld_rvalid),
    .ld_rdata   (ld_rdata),
    .mem_a      (mem_a),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] init_val(input logic [7:0] idx);
    case (idx)
      8'd64:   return 32'hDEADBEEF;
      8'd65:   return 32'h12345678;
      default: return {idx, ~idx, idx ^ 8'h3C, 8'hA5};
    endcase
  endfunction

  // Memory with one-cycle read latency, addressed through the DUT's port.
  logic [31:0] memarr [256];
  bit          mem_wv [256];
  always @(posedge clk) begin
    if (mem_we) begin
      memarr[mem_a[9:2]] <= mem_wd;
      mem_wv[mem_a[9:2]] <= 1'b1;
    end
    mem_rd <= mem_wv[mem_a[9:2]] ? memarr[mem_a[9:2]] : init_val(mem_a[9:2]);
  end

  // Reference contents, updated from the requesters' own inputs.
  logic [31:0] refm [256];
  bit          ref_wv [256];
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_wv[a[9:2]] ? refm[a[9:2]] : init_val(a[9:2]);
  endfunction

  typedef struct {
    int          cyc;
    bit          own;
    logic [31:0] data;
  } rd_t;
  rd_t q[$];
  int  mcyc = 0;

  always @(negedge clk) begin
    bit          ecv, elv;
    logic [31:0] ed;
    rd_t         e;
    mcyc++;
    if (rst) begin
      q.delete();
    end else begin
      ecv = 1'b0;
      elv = 1'b0;
      ed  = '0;
      if (q.size() > 0 && q[0].cyc == mcyc - 1) begin
        e   = q.pop_front();
        ecv = (e.own == 1'b0);
        elv = (e.own == 1'b1);
        ed  = e.data;
      end
      if (ecv || elv || cpu_rvalid || ld_rvalid) begin
        chk("sb_cpu_rvalid", 64'(cpu_rvalid), 64'(ecv));
        chk("sb_ld_rvalid", 64'(ld_rvalid), 64'(elv));
        chk("sb_cpu_rdata", 64'(cpu_rdata), ecv ? 64'(ed) : 64'd0);
        chk("sb_ld_rdata", 64'(ld_rdata), elv ? 64'(ed) : 64'd0);
      end
      if (cpu_gnt && !cpu_we) q.push_back('{mcyc, 1'b0, ref_rd(cpu_addr)});
      if (ld_gnt && !ld_we) q.push_back('{mcyc, 1'b1, ref_rd(ld_addr)});
      if (cpu_gnt && cpu_we) begin
        refm[cpu_addr[9:2]]   = cpu_wdata;
        ref_wv[cpu_addr[9:2]] = 1'b1;
      end
      if (ld_gnt && ld_we) begin
        refm[ld_addr[9:2]]   = ld_wdata;
        ref_wv[ld_addr[9:2]] = 1'b1;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    ld_req  = 1'b0;
    ld_we   = 1'b0;
    ld_lock = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cpu_addr  = 32'h100;
    ld_addr   = 32'h104;
    cpu_wdata = 32'h0;
    ld_wdata  = 32'h0;
    cpu_req   = 1'b1;
    ld_req    = 1'b1;
    repeat (2) next_cycle();

    @(negedge clk);
    chk("rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
    chk("rst_ld_gnt", 64'(ld_gnt), 64'd0);
    chk("rst_cpu_stall", 64'(cpu_stall), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_rvalid", 64'({cpu_rvalid, ld_rvalid}), 64'd0);
    next_cycle();
    rst = 1'b0;

    // Contention: loader gets one slot in five.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("cont_cpu_gnt_c%0d", c), 64'(cpu_gnt), 64'(c % 5 != 4));
      chk($sformatf("cont_ld_gnt_c%0d", c), 64'(ld_gnt), 64'(c % 5 == 4));
      chk($sformatf("cont_stall_c%0d", c), 64'(cpu_stall), 64'(c % 5 == 4));
      next_cycle();
    end
    idle();
    next_cycle();

    // Locked burst, CPU arrives at cycle 2.
    ld_req  = 1'b1;
    ld_lock = 1'b1;
    ld_addr = 32'h20;
    for (int c = 0; c < 9; c++) begin
      cpu_req = (c >= 2);
      @(negedge clk);
      chk($sformatf("burst_ld_gnt_c%0d", c), 64'(ld_gnt), 64'(c < 8));
      chk($sformatf("burst_cpu_gnt_c%0d", c), 64'(cpu_gnt), 64'(c == 8));
      chk($sformatf("burst_stall_c%0d", c), 64'(cpu_stall), 64'(c >= 2 && c < 8));
      next_cycle();
    end
    idle();
    next_cycle();

    // Read routing.
    cpu_req  = 1'b1;
    cpu_addr = 32'h100;
    next_cycle();
    cpu_req = 1'b0;
    ld_req  = 1'b1;
    ld_addr = 32'h104;
    @(negedge clk);
    chk("rd_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    chk("rd_cpu_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
    chk("rd_ld_rvalid_c1", 64'(ld_rvalid), 64'd0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("rd_ld_rvalid", 64'(ld_rvalid), 64'd1);
    chk("rd_ld_rdata", 64'(ld_rdata), 64'h12345678);
    chk("rd_cpu_rvalid_c2", 64'(cpu_rvalid), 64'd0);
    chk("rd_cpu_rdata_c2", 64'(cpu_rdata), 64'd0);
    next_cycle();

    // Loader write, then CPU reads it back.
    ld_req   = 1'b1;
    ld_we    = 1'b1;
    ld_addr  = 32'h40;
    ld_wdata = 32'hAB;
    @(negedge clk);
    chk("wr_ld_gnt", 64'(ld_gnt), 64'd1);
    chk("wr_mem_we", 64'(mem_we), 64'd1);
    chk("wr_mem_a", 64'(mem_a), 64'h40);
    chk("wr_mem_wd", 64'(mem_wd), 64'hAB);
    next_cycle();
    idle();
    @(negedge clk);
    chk("wr_no_rvalid", 64'({cpu_rvalid, ld_rvalid}), 64'd0);
    chk("idle_mem_a", 64'(mem_a), 64'd0);
    next_cycle();
    cpu_req  = 1'b1;
    cpu_addr = 32'h40;
    next_cycle();
    idle();
    @(negedge clk);
    chk("wr_readback", 64'(cpu_rdata), 64'hAB);
    next_cycle();

    // Asynchronous reset at beat 3 of a read burst.
    ld_req  = 1'b1;
    ld_lock = 1'b1;
    ld_addr = 32'h80;
    for (int c = 0; c < 3; c++) begin
      cpu_req = (c >= 1);
      @(negedge clk);
      chk($sformatf("ar_ld_gnt_c%0d", c), 64'(ld_gnt), 64'd1);
      next_cycle();
    end
    #2;
    chk("ar_pre_ld_gnt", 64'(ld_gnt), 64'd1);
    rst = 1'b1;
    #1;
    chk("ar_ld_gnt", 64'(ld_gnt), 64'd0);
    chk("ar_cpu_stall", 64'(cpu_stall), 64'd0);
    chk("ar_mem_a", 64'(mem_a), 64'd0);
    chk("ar_rvalid", 64'({cpu_rvalid, ld_rvalid}), 64'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("ar_cpu_gnt", 64'(cpu_gnt), 64'd1);
    chk("ar_ld_gnt_after", 64'(ld_gnt), 64'd0);
    chk("ar_no_rvalid", 64'({cpu_rvalid, ld_rvalid}), 64'd0);
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("ar_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    chk("ar_ld_gnt_next", 64'(ld_gnt), 64'd1);
    next_cycle();
    idle();
    repeat (3) next_cycle();
    @(negedge clk);
    chk("sb_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
